// File: rtl/control_pipe.sv
// Pipelined main-control unit: decodes the ID opcode, carries the control bundle through
// ID/EX, EX/MEM and MEM/WB, and produces stall/bubble control for load-use, flush and vector ops.
module control_pipe #(
  parameter int VEC_ELEMS = 16,
  parameter int VEC_LANES = 4,
  localparam int BEATS = VEC_ELEMS / VEC_LANES,
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  input  logic [6:0]    Op_i,
  input  logic [4:0]    rd_i,
  input  logic [4:0]    rs1_i,
  input  logic [4:0]    rs2_i,
  input  logic          flush_i,
  output logic          stall_o,
  output logic [1:0]    ex_ALUOp_o,
  output logic          ex_ALUSrc_o,
  output logic          ex_immSelect_o,
  output logic [4:0]    ex_rd_o,
  output logic [BW-1:0] vec_beat_o,
  output logic          vec_last_o,
  output logic          mem_MemRd_o,
  output logic          mem_MemWr_o,
  output logic          wb_RegWrite_o,
  output logic          wb_MemToReg_o,
  output logic          illegal_o
);

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  // Control bundle layout: [7:6] ALUOp, [5] ALUSrc, [4] RegWrite, [3] MemRd,
  // [2] MemWr, [1] MemToReg, [0] immSelect.
  logic [7:0]    dec_ctrl;
  logic          dec_legal;
  logic          dec_uses_rs2;
  logic          dec_is_vec;

  logic [7:0]    ex_ctrl_reg;
  logic [4:0]    ex_rd_reg;
  logic          ex_vec_reg;
  logic [BW-1:0] beat_reg;
  logic          illegal_reg;
  logic          flush_pend_reg;
  logic [3:0]    mem_ctrl_reg;   // {RegWrite, MemRd, MemWr, MemToReg}
  logic [1:0]    wb_ctrl_reg;    // {RegWrite, MemToReg}

  logic          vec_busy;
  logic          squash;
  logic          src_hit;
  logic          load_use;

  always_comb begin
    dec_ctrl     = 8'b0;
    dec_legal    = 1'b1;
    dec_uses_rs2 = 1'b0;
    dec_is_vec   = 1'b0;
    case (Op_i)
      7'b0010011: dec_ctrl = 8'b11_1_1_0_0_0_0;
      7'b0110011: begin dec_ctrl = 8'b10_0_1_0_0_0_0; dec_uses_rs2 = 1'b1; end
      7'b1100011: begin dec_ctrl = 8'b01_1_0_0_0_0_0; dec_uses_rs2 = 1'b1; end
      7'b0000011: dec_ctrl = 8'b00_1_1_1_0_1_0;
      7'b0100011: begin dec_ctrl = 8'b00_1_0_0_1_0_1; dec_uses_rs2 = 1'b1; end
      7'b1010111: begin
        dec_ctrl     = 8'b00_0_1_0_0_0_0;
        dec_uses_rs2 = 1'b1;
        dec_is_vec   = 1'b1;
      end
      default:    dec_legal = 1'b0;
    endcase
  end

  // A flush seen while a vector occupies EX is remembered until the vector drains.
  assign vec_busy = ex_vec_reg && (beat_reg != LAST_BEAT);
  assign squash   = flush_i || flush_pend_reg;
  assign src_hit  = valid_i && dec_legal &&
                    ((rs1_i == ex_rd_reg) || (dec_uses_rs2 && (rs2_i == ex_rd_reg)));
  assign load_use = ex_ctrl_reg[3] && (ex_rd_reg != 5'd0) && src_hit && !squash;
  assign stall_o  = vec_busy || load_use;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_ctrl_reg    <= 8'b0;
      ex_rd_reg      <= 5'd0;
      ex_vec_reg     <= 1'b0;
      beat_reg       <= '0;
      illegal_reg    <= 1'b0;
      flush_pend_reg <= 1'b0;
      mem_ctrl_reg   <= 4'b0;
      wb_ctrl_reg    <= 2'b0;
    end else begin
      if (vec_busy) begin
        beat_reg    <= beat_reg + BW'(1);
        illegal_reg <= 1'b0;
        if (flush_i) flush_pend_reg <= 1'b1;
      end else begin
        beat_reg       <= '0;
        flush_pend_reg <= 1'b0;
        if (squash || load_use || !valid_i) begin
          ex_ctrl_reg <= 8'b0;
          ex_rd_reg   <= 5'd0;
          ex_vec_reg  <= 1'b0;
          illegal_reg <= 1'b0;
        end else begin
          ex_ctrl_reg <= dec_ctrl;
          ex_rd_reg   <= dec_legal ? rd_i : 5'd0;
          ex_vec_reg  <= dec_is_vec;
          illegal_reg <= !dec_legal;
        end
      end
      // Non-final vector beats send a bubble down the back end.
      mem_ctrl_reg <= vec_busy ? 4'b0 :
                      {ex_ctrl_reg[4], ex_ctrl_reg[3], ex_ctrl_reg[2], ex_ctrl_reg[1]};
      wb_ctrl_reg  <= {mem_ctrl_reg[3], mem_ctrl_reg[0]};
    end
  end

  assign ex_ALUOp_o     = ex_ctrl_reg[7:6];
  assign ex_ALUSrc_o    = ex_ctrl_reg[5];
  assign ex_immSelect_o = ex_ctrl_reg[0];
  assign ex_rd_o        = ex_rd_reg;
  assign vec_beat_o     = beat_reg;
  assign vec_last_o     = ex_vec_reg && (beat_reg == LAST_BEAT);
  assign illegal_o      = illegal_reg;
  assign mem_MemRd_o    = mem_ctrl_reg[2];
  assign mem_MemWr_o    = mem_ctrl_reg[1];
  assign wb_RegWrite_o  = wb_ctrl_reg[1];
  assign wb_MemToReg_o  = wb_ctrl_reg[0];

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: instruction-level model checked every cycle, plus directed
// sequences with hand-computed expectations (default geometry and a single-beat instance).
module tb_control_pipe;

  localparam int BEATS = 4;
  localparam logic [6:0] ADDI = 7'b0010011, RTYP = 7'b0110011, BEQ = 7'b1100011;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, VEC = 7'b1010111, BAD = 7'b1111111;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic valid_i = 1'b0;
  logic [6:0] op = 7'd0;
  logic [4:0] rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
  logic flush = 1'b0;

  logic stall, ex_alusrc, ex_imm, vec_last, mem_rd, mem_wr, wb_rw, wb_m2r, illegal;
  logic [1:0] ex_aluop, vec_beat;
  logic [4:0] ex_rd;
  logic stall2, ex_alusrc2, ex_imm2, vec_last2, mem_rd2, mem_wr2, wb_rw2, wb_m2r2, illegal2;
  logic [1:0] ex_aluop2;
  logic [0:0] vec_beat2;
  logic [4:0] ex_rd2;

  control_pipe dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .Op_i(op), .rd_i(rd), .rs1_i(rs1),
    .rs2_i(rs2), .flush_i(flush), .stall_o(stall), .ex_ALUOp_o(ex_aluop),
    .ex_ALUSrc_o(ex_alusrc), .ex_immSelect_o(ex_imm), .ex_rd_o(ex_rd),
    .vec_beat_o(vec_beat), .vec_last_o(vec_last), .mem_MemRd_o(mem_rd),
    .mem_MemWr_o(mem_wr), .wb_RegWrite_o(wb_rw), .wb_MemToReg_o(wb_m2r),
    .illegal_o(illegal)
  );

  control_pipe #(.VEC_ELEMS(16), .VEC_LANES(16)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .Op_i(op), .rd_i(rd), .rs1_i(rs1),
    .rs2_i(rs2), .flush_i(flush), .stall_o(stall2), .ex_ALUOp_o(ex_aluop2),
    .ex_ALUSrc_o(ex_alusrc2), .ex_immSelect_o(ex_imm2), .ex_rd_o(ex_rd2),
    .vec_beat_o(vec_beat2), .vec_last_o(vec_last2), .mem_MemRd_o(mem_rd2),
    .mem_MemWr_o(mem_wr2), .wb_RegWrite_o(wb_rw2), .wb_MemToReg_o(wb_m2r2),
    .illegal_o(illegal2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Decode table: {legal, uses_rs2, ALUOp[1:0], ALUSrc, RegWrite, MemRd, MemWr, MemToReg, immSelect}
  function automatic logic [9:0] spec_dec(input logic [6:0] o);
    case (o)
      ADDI:    return {2'b10, 8'b11110000};
      RTYP:    return {2'b11, 8'b10010000};
      BEQ:     return {2'b11, 8'b01100000};
      LW:      return {2'b10, 8'b00111010};
      SW:      return {2'b11, 8'b00100101};
      VEC:     return {2'b11, 8'b00010000};
      default: return 10'b0;
    endcase
  endfunction

  // Instruction-level model: what sits in EX, how many beats it has done, and the back end.
  logic [7:0] m_ex = 8'h0, m_mem = 8'h0, m_wb = 8'h0;
  logic [4:0] m_rd = 5'd0;
  logic m_vec = 1'b0, m_ill = 1'b0, m_pend = 1'b0;
  int m_beat = 0;
  logic [9:0] m_id;
  logic m_busy, m_hazard, m_stall;

  always_comb begin
    m_id     = spec_dec(op);
    m_busy   = m_vec && (m_beat < BEATS - 1);
    m_hazard = m_ex[3] && (m_rd != 5'd0) && valid_i && m_id[9] &&
               ((rs1 == m_rd) || (m_id[8] && (rs2 == m_rd))) && !flush && !m_pend;
    m_stall  = rst_i && (m_busy || m_hazard);
  end

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      m_ex <= 8'h0; m_mem <= 8'h0; m_wb <= 8'h0; m_rd <= 5'd0;
      m_vec <= 1'b0; m_ill <= 1'b0; m_pend <= 1'b0; m_beat <= 0;
    end else begin
      m_mem <= m_busy ? 8'h0 : m_ex;
      m_wb  <= m_mem;
      if (m_busy) begin
        m_beat <= m_beat + 1;
        m_ill  <= 1'b0;
        if (flush) m_pend <= 1'b1;
      end else begin
        m_beat <= 0;
        m_pend <= 1'b0;
        if (flush || m_pend || m_hazard || !valid_i || !m_id[9]) begin
          m_ex  <= 8'h0;
          m_rd  <= 5'd0;
          m_vec <= 1'b0;
          m_ill <= valid_i && !flush && !m_pend && !m_id[9];
        end else begin
          m_ex  <= m_id[7:0];
          m_rd  <= rd;
          m_vec <= (op == VEC);
          m_ill <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("stall", int'(stall), int'(m_stall));
    chk("ex_ALUOp", int'(ex_aluop), int'(m_ex[7:6]));
    chk("ex_ALUSrc", int'(ex_alusrc), int'(m_ex[5]));
    chk("ex_immSelect", int'(ex_imm), int'(m_ex[0]));
    chk("ex_rd", int'(ex_rd), int'(m_rd));
    chk("vec_beat", int'(vec_beat), m_beat);
    chk("vec_last", int'(vec_last), int'(m_vec && (m_beat == BEATS - 1)));
    chk("illegal", int'(illegal), int'(m_ill));
    chk("mem_MemRd", int'(mem_rd), int'(m_mem[3]));
    chk("mem_MemWr", int'(mem_wr), int'(m_mem[2]));
    chk("wb_RegWrite", int'(wb_rw), int'(m_wb[4]));
    chk("wb_MemToReg", int'(wb_m2r), int'(m_wb[1]));
  end

  task automatic drive(input logic v, input logic [6:0] o, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic f);
    valid_i = v; op = o; rd = d; rs1 = s1; rs2 = s2; flush = f;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] ops [7] = '{ADDI, RTYP, BEQ, LW, SW, VEC, BAD};
  logic [7:0] tab [7] = '{8'b11110000, 8'b10010000, 8'b01100000, 8'b00111010,
                          8'b00100101, 8'b00010000, 8'b00000000};

  initial begin
    int wb_cnt, wb2_cnt;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_ex_ALUOp", int'(ex_aluop), 0);
    chk("rst_stall", int'(stall), 0);
    chk("rst_wb_RegWrite", int'(wb_rw), 0);
    rst_i = 1'b1;
    next();

    // Decode sweep: one instruction, then idle until it drains.
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, ops[i], 5'(i + 1), 5'd0, 5'd0, 1'b0);
      next();
      drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      #2;
      chk("sweep_ex_ALUOp", int'(ex_aluop), int'(tab[i][7:6]));
      chk("sweep_ex_ALUSrc", int'(ex_alusrc), int'(tab[i][5]));
      chk("sweep_ex_imm", int'(ex_imm), int'(tab[i][0]));
      chk("sweep_illegal", int'(illegal), (i == 6) ? 1 : 0);
      chk("sweep_ex_rd", int'(ex_rd), (i == 6) ? 0 : i + 1);
      next();
      #2;
      chk("sweep_mem_MemRd", int'(mem_rd), int'(tab[i][3]));
      chk("sweep_mem_MemWr", int'(mem_wr), int'(tab[i][2]));
      next();
      #2;
      chk("sweep_wb_RegWrite", int'(wb_rw), (i == 5) ? 0 : int'(tab[i][4]));
      chk("sweep_wb_MemToReg", int'(wb_m2r), int'(tab[i][1]));
      repeat (4) next();
    end

    // Load-use: lw x5 then add x6,x5,x2.
    drive(1'b1, LW, 5'd5, 5'd1, 5'd0, 1'b0);
    next();
    drive(1'b1, RTYP, 5'd6, 5'd5, 5'd2, 1'b0);
    #2;
    chk("lu_stall", int'(stall), 1);
    next();
    #2;
    chk("lu_stall_once", int'(stall), 0);
    chk("lu_bubble_ALUOp", int'(ex_aluop), 0);
    chk("lu_bubble_rd", int'(ex_rd), 0);
    next();
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    #2;
    chk("lu_add_ALUOp", int'(ex_aluop), 2);
    repeat (3) next();

    // Same with rd=x0: no hazard.
    drive(1'b1, LW, 5'd0, 5'd1, 5'd0, 1'b0);
    next();
    drive(1'b1, RTYP, 5'd6, 5'd0, 5'd2, 1'b0);
    #2;
    chk("x0_stall", int'(stall), 0);
    next();
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    #2;
    chk("x0_add_ALUOp", int'(ex_aluop), 2);
    repeat (3) next();

    // Vector issue with a beq waiting in ID.
    drive(1'b1, VEC, 5'd7, 5'd1, 5'd2, 1'b0);
    next();
    drive(1'b1, BEQ, 5'd0, 5'd3, 5'd4, 1'b0);
    wb_cnt = 0;
    wb2_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      #2;
      if (k < 4) begin
        chk("vec_beat_seq", int'(vec_beat), k);
        chk("vec_last_seq", int'(vec_last), (k == 3) ? 1 : 0);
        chk("vec_stall_seq", int'(stall), (k < 3) ? 1 : 0);
      end
      if (k == 5) chk("vec_wb_time", int'(wb_rw), 1);
      if (k == 0) begin
        chk("v1_stall", int'(stall2), 0);
        chk("v1_last", int'(vec_last2), 1);
        chk("v1_beat", int'(vec_beat2), 0);
        chk("v1_ex_rd", int'(ex_rd2), 7);
        chk("v1_illegal", int'(illegal2), 0);
      end
      if (k == 2) begin
        chk("v1_wb_time", int'(wb_rw2), 1);
        chk("v1_wb_m2r", int'(wb_m2r2), 0);
      end
      wb_cnt += int'(wb_rw);
      wb2_cnt += int'(wb_rw2);
      next();
    end
    chk("vec_wb_pulses", wb_cnt, 1);
    chk("v1_wb_pulses", wb2_cnt, 1);

    // Flush beats load-use.
    drive(1'b1, LW, 5'd9, 5'd1, 5'd0, 1'b0);
    next();
    drive(1'b1, RTYP, 5'd6, 5'd9, 5'd2, 1'b1);
    #2;
    chk("fl_stall", int'(stall), 0);
    next();
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    #2;
    chk("fl_bubble_ALUOp", int'(ex_aluop), 0);
    chk("fl_bubble_rd", int'(ex_rd), 0);
    repeat (3) next();

    // Flush during vector beat 1: vector finishes, the waiting addi is squashed.
    drive(1'b1, VEC, 5'd10, 5'd1, 5'd2, 1'b0);
    next();
    drive(1'b1, ADDI, 5'd11, 5'd1, 5'd0, 1'b0);
    wb_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      flush = (k == 1);
      if (k == 4) drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      #2;
      if (k == 3) chk("vf_last", int'(vec_last), 1);
      if (k == 4) begin
        chk("vf_bubble_ALUOp", int'(ex_aluop), 0);
        chk("vf_bubble_rd", int'(ex_rd), 0);
      end
      wb_cnt += int'(wb_rw);
      next();
    end
    chk("vf_wb_pulses", wb_cnt, 1);

    // Reset during vector beat 1.
    drive(1'b1, VEC, 5'd12, 5'd1, 5'd2, 1'b0);
    next();
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    next();
    #2;
    rst_i = 1'b0;
    #1;
    chk("rv_stall", int'(stall), 0);
    chk("rv_ex_rd", int'(ex_rd), 0);
    chk("rv_beat", int'(vec_beat), 0);
    chk("rv_last", int'(vec_last), 0);
    chk("rv_mem", int'({mem_rd, mem_wr}), 0);
    chk("rv_wb", int'({wb_rw, wb_m2r}), 0);
    chk("rv_illegal", int'(illegal), 0);
    @(posedge clk);
    #3;
    rst_i = 1'b1;
    wb_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      next();
      #2;
      wb_cnt += int'(wb_rw);
    end
    chk("rv_wb_pulses", wb_cnt, 0);

    repeat (2) next();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/control_pipe.md
# control_pipe

Pipelined main-control unit for the RISC-V core, the successor to the single-cycle combinational decoder. It decodes the ID-stage opcode and carries the control bundle through registered ID/EX, EX/MEM and MEM/WB stages. It also generates the stall and bubble control for load-use hazards, branch flushes and multi-beat vector operations, with vector geometry set by parameters. Unknown opcodes become bubbles and are flagged, instead of executing as addi.

## Interface
- VEC_ELEMS, 16: elements per vector instruction.
- VEC_LANES, 4: elements processed per EX beat. VEC_ELEMS must be divisible by VEC_LANES; BEATS = VEC_ELEMS/VEC_LANES ≥ 1.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  ID stage holds a real instruction.
- Op_i  in  7  ID opcode.
- rd_i / rs1_i / rs2_i  in  5 each  ID register fields.
- flush_i  in  1  branch taken, resolved in EX; squashes the ID instruction.
- stall_o  out  1  freeze PC and IF/ID (combinational).
- ex_ALUOp_o  out  2;  ex_ALUSrc_o  out  1;  ex_immSelect_o  out  1: EX-stage control.
- ex_rd_o  out  5: EX-stage rd.
- vec_beat_o  out  $clog2(BEATS) (min 1): current vector beat in EX.
- vec_last_o  out  1: EX holds the final vector beat.
- mem_MemRd_o / mem_MemWr_o  out  1 each: MEM-stage control.
- wb_RegWrite_o / wb_MemToReg_o  out  1 each: WB-stage control.
- illegal_o  out  1: one-cycle pulse when an unknown opcode enters EX as a bubble.

## Operation
- Decode, as {ALUOp, ALUSrc, RegWrite, MemRd, MemWr, MemToReg, immSelect}:
  - 0010011 addi: 11,1,1,0,0,0,0
  - 0110011 R-type: 10,0,1,0,0,0,0
  - 1100011 beq: 01,1,0,0,0,0,0
  - 0000011 lw: 00,1,1,1,0,1,0
  - 0100011 sw: 00,1,0,0,1,0,1
  - 1010111 vector: 00,0,1,0,0,0,0
  - Any other opcode: all zero (bubble), and illegal_o pulses.
- rs2 is used by R-type, beq, sw and vector. rs1 is used by every legal opcode.
- Load-use hazard: EX holds a lw, ex_rd_o ≠ 0, and ex_rd_o equals a used source of the valid ID instruction. Then stall_o=1 for one cycle, and a bubble enters EX.
- Vector issue: on entering EX, vec_beat_o=0. The EX stage holds the instruction while the beat counter advances each cycle up to BEATS-1.
  - stall_o=1 while the beat counter < BEATS-1.
  - RegWrite propagates to MEM only on the last beat; earlier beats send a bubble (all zero) to MEM.
  - vec_last_o=1 on the last beat.
  - BEATS=1: no stall, vec_last_o=1 on issue.
- Priority on the ID→EX transfer:
  1. Vector busy holds EX; flush_i still clears the ID instruction, so EX gets a bubble after the vector finishes.
  2. flush_i: bubble into EX, no load-use stall.
  3. Load-use: bubble plus stall.
  4. Otherwise the decoded bundle (bubble if valid_i=0).
- MEM and WB stages always advance, with no stall in the back end.

## Timing
- Reset (rst_i=0, async): every registered output is 0. This covers all ex_*, mem_*, wb_*, ex_rd_o, vec_beat_o, vec_last_o and illegal_o; the beat counter also clears.
- stall_o is combinational from EX state and ID inputs; it is 0 during reset.
- Reset mid-vector aborts the vector immediately; no RegWrite reaches WB.
- Latency: an instruction in ID at cycle t appears on ex_* at t+1, mem_* at t+2 and wb_* at t+3.
  - A vector's write appears on mem_* at t+BEATS+1 and wb_* at t+BEATS+2.
- illegal_o is high in the same cycle the bubble sits in EX.
- A load-use stall lasts exactly one cycle. The stalled instruction enters EX at t+2, after the lw has moved to MEM.

## Test plan
- Reset mid-vector: assert rst_i=0 asynchronously during beat 1 -> all outputs 0 immediately; no wb_RegWrite_o pulse after release.
- Decode sweep: present each of the six legal opcodes, valid_i=1 -> ex_* matches the decode table at t+1, mem_* at t+2, wb_* at t+3; Op_i=1111111 -> illegal_o=1 at t+1 and all-zero bundle.
- Load-use: lw x5, then add rs1=x5 -> stall_o=1 for one cycle, ex_* all zero that cycle, add's ALUOp=10 appears one cycle later; same sequence with rd=x0 -> no stall.
- Vector with defaults (BEATS=4): issue vector -> stall_o=1 for 3 cycles, vec_beat_o=0,1,2,3, vec_last_o only at beat 3, a single wb_RegWrite_o pulse 2 cycles after beat 3; repeat with VEC_LANES=16 -> no stall.
- Flush vs hazard: lw in EX, dependent instruction in ID, flush_i=1 -> stall_o=0, bubble into EX; flush_i during vector beat 1 -> vector completes, then a bubble follows.
